// File: rtl/rx_fsm.sv
// HS lane receiver: hunts for the sync byte, delivers payload bytes with one
// cycle of latency, and acknowledges the transmitter a fixed delay after EOT.
module rx_fsm #(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter logic [7:0] SYNC_TIMEOUT = 8'h0F,
  parameter logic [7:0] ACK_DELAY    = 8'h02
) (
  input  logic        TxDDRClk,
  input  logic        TxRst,
  input  logic        RxLineValid,
  input  logic [7:0]  RxDataIn,
  output logic [7:0]  RxByteHS,
  output logic        RxValidHS,
  output logic        RxActiveHS,
  output logic        RxSyncHS,
  output logic        ErrSotHS,
  output logic        AckOut,
  output logic [15:0] RxByteCount
);

  localparam logic [2:0] RX_IDLE = 3'd0;
  localparam logic [2:0] RX_SYNC = 3'd1;
  localparam logic [2:0] RX_DATA = 3'd2;
  localparam logic [2:0] RX_EOT  = 3'd3;
  localparam logic [2:0] RX_ERR  = 3'd4;

  logic [2:0]  stateReg, stateNext;
  logic [7:0]  syncCntReg, syncCntNext;
  logic [7:0]  eotCntReg, eotCntNext;
  logic [7:0]  byteNext;
  logic [15:0] countNext;
  logic        validNext, activeNext, syncNext, errNext, ackNext;
  logic [7:0]  syncInc;

  always_comb begin
    stateNext   = stateReg;
    syncCntNext = syncCntReg;
    eotCntNext  = eotCntReg;
    byteNext    = RxByteHS;
    countNext   = RxByteCount;
    validNext   = 1'b0;
    syncNext    = 1'b0;
    errNext     = 1'b0;
    ackNext     = 1'b0;
    // The first byte of a burst is already a sync candidate, so the hunt
    // counter starts from zero when leaving idle.
    syncInc     = ((stateReg == RX_SYNC) ? syncCntReg : 8'h00) + 8'h01;

    case (stateReg)
      RX_IDLE, RX_SYNC: begin
        if (RxLineValid) begin
          if (stateReg == RX_IDLE) begin
            countNext  = 16'h0000;
            eotCntNext = 8'h00;
          end
          if (RxDataIn == SYNC_BYTE) begin
            stateNext   = RX_DATA;
            syncNext    = 1'b1;
            syncCntNext = 8'h00;
          end else if (syncInc == SYNC_TIMEOUT) begin
            stateNext   = RX_ERR;
            errNext     = 1'b1;
            syncCntNext = syncInc;
          end else begin
            stateNext   = RX_SYNC;
            syncCntNext = syncInc;
          end
        end else if (stateReg == RX_SYNC) begin
          stateNext   = RX_IDLE;
          syncCntNext = 8'h00;
        end
      end
      RX_DATA: begin
        if (RxLineValid) begin
          byteNext  = RxDataIn;
          validNext = 1'b1;
          countNext = RxByteCount + 16'h0001;
        end else begin
          stateNext  = RX_EOT;
          eotCntNext = 8'h00;
        end
      end
      RX_EOT: begin
        // Line activity here is ignored; the ack always completes first.
        if (eotCntReg == ACK_DELAY) begin
          stateNext  = RX_IDLE;
          ackNext    = 1'b1;
          eotCntNext = 8'h00;
        end else begin
          eotCntNext = eotCntReg + 8'h01;
        end
      end
      RX_ERR: begin
        if (!RxLineValid) begin
          stateNext   = RX_IDLE;
          syncCntNext = 8'h00;
        end
      end
      default: begin
        stateNext   = RX_IDLE;
        syncCntNext = 8'h00;
        eotCntNext  = 8'h00;
      end
    endcase

    activeNext = (stateNext == RX_SYNC) || (stateNext == RX_DATA);
  end

  always_ff @(posedge TxDDRClk or negedge TxRst) begin
    if (!TxRst) begin
      stateReg    <= RX_IDLE;
      syncCntReg  <= 8'h00;
      eotCntReg   <= 8'h00;
      RxByteHS    <= 8'h00;
      RxValidHS   <= 1'b0;
      RxActiveHS  <= 1'b0;
      RxSyncHS    <= 1'b0;
      ErrSotHS    <= 1'b0;
      AckOut      <= 1'b0;
      RxByteCount <= 16'h0000;
    end else begin
      stateReg    <= stateNext;
      syncCntReg  <= syncCntNext;
      eotCntReg   <= eotCntNext;
      RxByteHS    <= byteNext;
      RxValidHS   <= validNext;
      RxActiveHS  <= activeNext;
      RxSyncHS    <= syncNext;
      ErrSotHS    <= errNext;
      AckOut      <= ackNext;
      RxByteCount <= countNext;
    end
  end

endmodule

// File: tb/tb_rx_fsm.sv
// Scoreboard bench for rx_fsm: payload bytes are queued when driven and
// compared as RxValidHS presents them; pulse counts and timing are tracked.
module tb_rx_fsm;

  logic        TxDDRClk;
  logic        TxRst;
  logic        RxLineValid;
  logic [7:0]  RxDataIn;
  logic [7:0]  RxByteHS;
  logic        RxValidHS, RxActiveHS, RxSyncHS, ErrSotHS, AckOut;
  logic [15:0] RxByteCount;

  rx_fsm dut (
    .TxDDRClk    (TxDDRClk),
    .TxRst       (TxRst),
    .RxLineValid (RxLineValid),
    .RxDataIn    (RxDataIn),
    .RxByteHS    (RxByteHS),
    .RxValidHS   (RxValidHS),
    .RxActiveHS  (RxActiveHS),
    .RxSyncHS    (RxSyncHS),
    .ErrSotHS    (ErrSotHS),
    .AckOut      (AckOut),
    .RxByteCount (RxByteCount)
  );

  localparam int ACK_DELAY = 2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] expQ[$];
  bit monEn = 0;
  int syncPulses, errPulses, ackPulses, validCount, activeCycles;
  int syncEdge, errEdge, ackEdge, lastEdge, dropEdge;

  initial begin
    TxDDRClk = 1'b0;
    forever #5 TxDDRClk = ~TxDDRClk;
  end

  always @(posedge TxDDRClk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge TxDDRClk) begin
    if (monEn) begin
      if (RxValidHS) begin
        validCount++;
        if (expQ.size() == 0) checkVal("unexpected_byte", {24'h0, RxByteHS}, 32'hFFFF_FFFF);
        else checkVal("payload_byte", {24'h0, RxByteHS}, {24'h0, expQ.pop_front()});
      end
      if (RxSyncHS)   begin syncPulses++; syncEdge = cyc; end
      if (ErrSotHS)   begin errPulses++;  errEdge  = cyc; end
      if (AckOut)     begin ackPulses++;  ackEdge  = cyc; end
      if (RxActiveHS) activeCycles++;
    end
  end

  task automatic clrMon();
    syncPulses = 0; errPulses = 0; ackPulses = 0; validCount = 0; activeCycles = 0;
    syncEdge = -1; errEdge = -1; ackEdge = -1;
  endtask

  task automatic send(input logic [7:0] b, input bit payload);
    @(negedge TxDDRClk);
    RxLineValid = 1'b1;
    RxDataIn    = b;
    lastEdge    = cyc + 1;
    if (payload) expQ.push_back(b);
  endtask

  task automatic drop();
    @(negedge TxDDRClk);
    RxLineValid = 1'b0;
    RxDataIn    = 8'h00;
    dropEdge    = cyc + 1;
  endtask

  task automatic waitAck(input int prev, input string tag);
    int n = 0;
    while (ackPulses == prev && n < 40) begin
      @(negedge TxDDRClk); #1;
      n++;
    end
    if (ackPulses == prev) checkVal({tag, "_ack_timeout"}, 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge TxDDRClk); #1;
    end
  endtask

  function automatic logic [31:0] allOuts();
    return {3'b0, RxByteHS, RxValidHS, RxActiveHS, RxSyncHS, ErrSotHS, AckOut, RxByteCount};
  endfunction

  initial begin
    int b8Edge, errExp;
    TxRst = 1'b0; RxLineValid = 1'b0; RxDataIn = 8'h00;
    clrMon();
    idle(3);
    checkVal("reset_outputs", allOuts(), 0);
    TxRst = 1'b1;
    monEn = 1;
    idle(2);
    checkVal("idle_outputs", allOuts(), 0);

    // Basic burst: two junk bytes, sync, three payload bytes
    clrMon();
    send(8'h00, 0); send(8'h00, 0); send(8'hB8, 0); b8Edge = lastEdge;
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    drop();
    waitAck(0, "basic");
    idle(4);
    checkVal("basic_sync_time", syncEdge, b8Edge);
    checkVal("basic_sync_pulses", syncPulses, 1);
    checkVal("basic_ack_pulses", ackPulses, 1);
    checkVal("basic_ack_delay", ackEdge - dropEdge, ACK_DELAY + 1);
    checkVal("basic_count", RxByteCount, 3);
    checkVal("basic_valid_cycles", validCount, 3);
    checkVal("basic_active_cycles", activeCycles, 6);
    checkVal("basic_byte_hold", RxByteHS, 8'h33);
    checkVal("basic_no_err", errPulses, 0);
    checkVal("basic_queue_empty", expQ.size(), 0);
    $display("burst basic: count=%0d acks=%0d", RxByteCount, ackPulses);

    // Sync timeout: 16 zero bytes
    clrMon();
    errExp = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'h00, 0);
      if (i == 14) errExp = lastEdge;
    end
    drop();
    idle(10);
    checkVal("sot_err_pulses", errPulses, 1);
    checkVal("sot_err_time", errEdge, errExp);
    checkVal("sot_no_valid", validCount, 0);
    checkVal("sot_no_ack", ackPulses, 0);
    checkVal("sot_no_sync", syncPulses, 0);
    checkVal("sot_active_cycles", activeCycles, 14);
    checkVal("sot_idle_active", RxActiveHS, 0);
    $display("burst timeout: errs=%0d acks=%0d", errPulses, ackPulses);

    // Sync byte only, then immediate drop
    clrMon();
    send(8'hB8, 0);
    drop();
    waitAck(0, "empty");
    checkVal("empty_count", RxByteCount, 0);
    checkVal("empty_ack_pulses", ackPulses, 1);
    checkVal("empty_sync_pulses", syncPulses, 1);
    checkVal("empty_no_valid", validCount, 0);
    $display("burst empty: count=%0d acks=%0d", RxByteCount, ackPulses);

    // Reset mid-burst, then a clean burst
    clrMon();
    send(8'hB8, 0); send(8'h11, 1); send(8'h22, 1);
    @(negedge TxDDRClk);
    RxDataIn = 8'h33;
    #2 TxRst = 1'b0;
    #1 checkVal("midrst_outputs", allOuts(), 0);
    RxLineValid = 1'b0;
    idle(2);
    TxRst = 1'b1;
    idle(8);
    checkVal("midrst_no_ack", ackPulses, 0);
    checkVal("midrst_idle_outs", allOuts(), 0);
    clrMon();
    send(8'hB8, 0); send(8'h5A, 1); send(8'hC3, 1);
    drop();
    waitAck(0, "postrst");
    checkVal("postrst_count", RxByteCount, 2);
    checkVal("postrst_valid", validCount, 2);
    checkVal("postrst_queue_empty", expQ.size(), 0);
    $display("burst after reset: count=%0d acks=%0d", RxByteCount, ackPulses);

    // Valid re-asserted during EOT
    clrMon();
    send(8'hB8, 0); send(8'h77, 1);
    drop();
    send(8'hB8, 0);
    waitAck(0, "back1");
    send(8'hAA, 1);
    drop();
    waitAck(1, "back2");
    checkVal("b2b_ack_pulses", ackPulses, 2);
    checkVal("b2b_sync_pulses", syncPulses, 2);
    checkVal("b2b_count", RxByteCount, 1);
    checkVal("b2b_last_byte", RxByteHS, 8'hAA);
    checkVal("b2b_valid", validCount, 2);
    $display("burst back-to-back: count=%0d acks=%0d", RxByteCount, ackPulses);

    // Byte counter wrap: 65537 payload bytes
    clrMon();
    send(8'hB8, 0);
    for (int i = 0; i < 65537; i++) send(i[7:0], 1);
    drop();
    waitAck(0, "wrap");
    checkVal("wrap_count", RxByteCount, 16'h0001);
    checkVal("wrap_valid", validCount, 65537);
    checkVal("wrap_queue_empty", expQ.size(), 0);
    $display("burst wrap: count=%0h acks=%0d", RxByteCount, ackPulses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_fsm.md
RX_FSM -- requirements
Module: rx_fsm

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hB8, HS start-of-transmission sync pattern.
REQ-002 Parameter SYNC_TIMEOUT, default 8'h0F, max non-sync bytes accepted in RX_SYNC before an SoT error.
REQ-003 Parameter ACK_DELAY, default 8'h02, cycles from end of burst to the AckOut pulse; legal range 1..8'hFF.
REQ-004 TxDDRClk  input  1  clock; all state and outputs update on the rising edge.
REQ-005 TxRst  input  1  reset, asynchronous, active-low.
REQ-006 RxLineValid  input  1  lane is in HS burst; mirrors the transmitter's valid.
REQ-007 RxDataIn  input  8  HS byte from lane, sampled when RxLineValid=1.
REQ-008 RxByteHS  output  8  received payload byte.
REQ-009 RxValidHS  output  1  RxByteHS holds a payload byte this cycle.
REQ-010 RxActiveHS  output  1  burst in progress (RX_SYNC or RX_DATA).
REQ-011 RxSyncHS  output  1  one-cycle pulse, sync byte detected.
REQ-012 ErrSotHS  output  1  one-cycle pulse, sync not found within SYNC_TIMEOUT bytes.
REQ-013 AckOut  output  1  one-cycle acknowledge pulse to the transmitter after EOT.
REQ-014 RxByteCount  output  16  payload bytes in current/last burst.

Function
REQ-015 The module SHALL implement states RX_IDLE, RX_SYNC, RX_DATA, RX_EOT and RX_ERR in a 3-bit state register.
REQ-016 All outputs SHALL be registered; output timing below is relative to the sampling edge.
REQ-017 RX_IDLE: RxLineValid=1 SHALL move to RX_SYNC and clear the sync counter and RxByteCount; the byte sampled on that edge SHALL also be checked as the first sync candidate.
REQ-018 RX_SYNC with RxLineValid=1 and RxDataIn==SYNC_BYTE SHALL move to RX_DATA and pulse RxSyncHS on the next cycle; the sync byte SHALL NOT be delivered as payload.
REQ-019 RX_SYNC with RxLineValid=1 and a non-sync byte SHALL increment the 8-bit sync counter; when the counter reaches SYNC_TIMEOUT, ErrSotHS SHALL pulse once and the state SHALL become RX_ERR.
REQ-020 RX_SYNC with RxLineValid=0 SHALL return to RX_IDLE with no AckOut and no ErrSotHS.
REQ-021 RX_DATA with RxLineValid=1 SHALL register RxByteHS<=RxDataIn and RxValidHS<=1, for 1-cycle latency, and increment RxByteCount.
REQ-022 RxByteCount SHALL wrap from 16'hFFFF to 16'h0000 and SHALL hold its value in RX_IDLE until the next burst starts.
REQ-023 RX_DATA with RxLineValid=0 SHALL move to RX_EOT; RxValidHS SHALL be 0 from that edge and RxByteHS SHALL hold the last byte.
REQ-024 RX_EOT SHALL count from 0; on the edge where the count equals ACK_DELAY, AckOut SHALL pulse for exactly one cycle and the state SHALL become RX_IDLE.
REQ-025 RxLineValid=1 during RX_EOT SHALL be ignored; the ack SHALL still complete, and RX_IDLE SHALL then start a new burst if RxLineValid is still 1.
REQ-026 RX_ERR SHALL hold, ignoring data, until RxLineValid=0, then return to RX_IDLE without AckOut.
REQ-027 RxActiveHS SHALL be 1 exactly in the cycles following edges on which the state is RX_SYNC or RX_DATA.
REQ-028 An illegal state encoding SHALL return to RX_IDLE on the next edge with all pulse outputs 0.
REQ-029 A burst with the sync byte followed immediately by RxLineValid=0 SHALL give RxByteCount=0 and still produce AckOut.

Reset
REQ-030 TxRst=0 SHALL immediately force RX_IDLE, RxByteHS=8'h00, RxValidHS=0, RxActiveHS=0, RxSyncHS=0, ErrSotHS=0, AckOut=0, RxByteCount=0, and all counters to 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no AckOut; after release, the block SHALL wait in RX_IDLE for RxLineValid=1.

Verification
REQ-032 Valid=1 with bytes 00,00,B8,11,22,33 and then valid=0 -> RxSyncHS is 1 cycle after B8; RxByteHS=11,22,33 with RxValidHS=1; RxByteCount=3; AckOut pulses once, ACK_DELAY+1 cycles after the valid drop.
REQ-033 Valid=1 with 16 bytes of 00 and no B8 -> a single ErrSotHS pulse after the 15th non-sync byte; no RxValidHS; no AckOut; RX_IDLE is reached after valid falls.
REQ-034 Valid=1, B8, then 65537 payload bytes -> RxByteCount=16'h0001 at EOT.
REQ-035 TxRst pulsed low after 2 payload bytes -> all outputs 0 immediately; no AckOut; the next clean burst is received correctly.
REQ-036 Valid re-asserted 1 cycle after the drop, with bytes B8,AA -> the first AckOut still occurs; the second burst then delivers AA with RxByteCount=1.
